// File: rtl/fpu_result_fifo.sv
// Purpose : show-ahead result FIFO behind the fpu, plus saturating exception/drop counters.
// Latency : a result pushed into an empty FIFO is visible on rd_*_out one cycle later.
// Backpres: rd_ready_in pops the head; results arriving while full with no pop are dropped and counted.
//
// Ports:
//   clock100KHz / reset        : rising-edge clock, asynchronous active-low reset
//   res_valid_in, data_in,
//   status_in, flags_in        : one-cycle result strobe and its payload
//   rd_ready_in, rd_valid_out,
//   rd_data/status/flags_out   : valid/ready read port showing the head entry (zero when empty)
//   level_out, full_out,
//   empty_out                  : occupancy
//   clear_cnt_in, *_cnt_out    : synchronous counter clear and saturating statistics counters
module fpu_result_fifo #(
    parameter int DEPTH = 8,
    parameter int CNT_W = 8
) (
    input  logic                       clock100KHz,
    input  logic                       reset,
    input  logic                       res_valid_in,
    input  logic [31:0]                data_in,
    input  logic [3:0]                 status_in,
    input  logic                       flags_in,
    input  logic                       rd_ready_in,
    output logic                       rd_valid_out,
    output logic [31:0]                rd_data_out,
    output logic [3:0]                 rd_status_out,
    output logic                       rd_flags_out,
    output logic [$clog2(DEPTH):0]     level_out,
    output logic                       full_out,
    output logic                       empty_out,
    input  logic                       clear_cnt_in,
    output logic [CNT_W-1:0]           ovf_cnt_out,
    output logic [CNT_W-1:0]           unf_cnt_out,
    output logic [CNT_W-1:0]           inx_cnt_out,
    output logic [CNT_W-1:0]           drop_cnt_out
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int LVL_W = PTR_W + 1;

    typedef struct packed {
        logic        flags;
        logic [3:0]  status;
        logic [31:0] data;
    } entry_t;

    entry_t             mem_q [DEPTH];
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [LVL_W-1:0]   level_q, level_d;
    logic [CNT_W-1:0]   ovf_cnt_q, ovf_cnt_d;
    logic [CNT_W-1:0]   unf_cnt_q, unf_cnt_d;
    logic [CNT_W-1:0]   inx_cnt_q, inx_cnt_d;
    logic [CNT_W-1:0]   drop_cnt_q, drop_cnt_d;

    logic   full, empty, pop, push, drop;
    entry_t head;

    // Increment by one unless already at all-ones.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c, input logic en);
        sat_inc = (en && (c != {CNT_W{1'b1}})) ? c + CNT_W'(1) : c;
    endfunction

    always_comb begin
        full  = (level_q == LVL_W'(DEPTH));
        empty = (level_q == '0);
        pop   = !empty && rd_ready_in;
        // A pop on the same edge frees a slot, so a full FIFO can still accept.
        push  = res_valid_in && (!full || pop);
        drop  = res_valid_in && full && !pop;

        rd_ptr_d = pop  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
        wr_ptr_d = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;

        level_d = level_q;
        if (push && !pop)      level_d = level_q + LVL_W'(1);
        else if (pop && !push) level_d = level_q - LVL_W'(1);

        if (clear_cnt_in) begin
            ovf_cnt_d  = '0;
            unf_cnt_d  = '0;
            inx_cnt_d  = '0;
            drop_cnt_d = '0;
        end else begin
            // Every set bit counts, so a multi-hot status bumps several counters.
            ovf_cnt_d  = sat_inc(ovf_cnt_q,  push && status_in[1]);
            unf_cnt_d  = sat_inc(unf_cnt_q,  push && status_in[2]);
            inx_cnt_d  = sat_inc(inx_cnt_q,  push && status_in[3]);
            drop_cnt_d = sat_inc(drop_cnt_q, drop);
        end

        // Storage is not reset, so mask the head while empty.
        head = empty ? '0 : mem_q[rd_ptr_q];
    end

    always_ff @(posedge clock100KHz or negedge reset) begin
        if (!reset) begin
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            level_q    <= '0;
            ovf_cnt_q  <= '0;
            unf_cnt_q  <= '0;
            inx_cnt_q  <= '0;
            drop_cnt_q <= '0;
        end else begin
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            level_q    <= level_d;
            ovf_cnt_q  <= ovf_cnt_d;
            unf_cnt_q  <= unf_cnt_d;
            inx_cnt_q  <= inx_cnt_d;
            drop_cnt_q <= drop_cnt_d;
        end
    end

    always_ff @(posedge clock100KHz) begin
        if (push) mem_q[wr_ptr_q] <= '{flags: flags_in, status: status_in, data: data_in};
    end

    assign rd_valid_out  = !empty;
    assign rd_data_out   = head.data;
    assign rd_status_out = head.status;
    assign rd_flags_out  = head.flags;
    assign level_out     = level_q;
    assign full_out      = full;
    assign empty_out     = empty;
    assign ovf_cnt_out   = ovf_cnt_q;
    assign unf_cnt_out   = unf_cnt_q;
    assign inx_cnt_out   = inx_cnt_q;
    assign drop_cnt_out  = drop_cnt_q;

endmodule

// File: tb/tb_fpu_result_fifo.sv
// Purpose : random and directed stimulus for fpu_result_fifo against a queue-based reference model.
// Latency : outputs are sampled 1 time unit after each rising edge.
// Backpres: the bench drives rd_ready_in randomly, including long stalls that fill the FIFO.
module tb_fpu_result_fifo;

    localparam int DEPTH = 8;
    localparam int CNT_W = 8;
    localparam int CMAX  = (1 << CNT_W) - 1;

    logic                   clk = 1'b0;
    logic                   rst_n;
    logic                   res_valid_in;
    logic [31:0]            data_in;
    logic [3:0]             status_in;
    logic                   flags_in;
    logic                   rd_ready_in;
    logic                   rd_valid_out;
    logic [31:0]            rd_data_out;
    logic [3:0]             rd_status_out;
    logic                   rd_flags_out;
    logic [$clog2(DEPTH):0] level_out;
    logic                   full_out;
    logic                   empty_out;
    logic                   clear_cnt_in;
    logic [CNT_W-1:0]       ovf_cnt_out, unf_cnt_out, inx_cnt_out, drop_cnt_out;

    fpu_result_fifo #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clock100KHz  (clk),
        .reset        (rst_n),
        .res_valid_in (res_valid_in),
        .data_in      (data_in),
        .status_in    (status_in),
        .flags_in     (flags_in),
        .rd_ready_in  (rd_ready_in),
        .rd_valid_out (rd_valid_out),
        .rd_data_out  (rd_data_out),
        .rd_status_out(rd_status_out),
        .rd_flags_out (rd_flags_out),
        .level_out    (level_out),
        .full_out     (full_out),
        .empty_out    (empty_out),
        .clear_cnt_in (clear_cnt_in),
        .ovf_cnt_out  (ovf_cnt_out),
        .unf_cnt_out  (unf_cnt_out),
        .inx_cnt_out  (inx_cnt_out),
        .drop_cnt_out (drop_cnt_out)
    );

    always #5 clk = ~clk;

    // Reference model: a queue of {flags,status,data} plus plain integer counters.
    logic [36:0] model_q[$];
    int          m_ovf, m_unf, m_inx, m_drop;
    int          n_chk  = 0;
    int          n_pass = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    endtask

    function automatic int sat(input int c, input bit en);
        return (en && c < CMAX) ? c + 1 : c;
    endfunction

    task automatic model_reset();
        model_q.delete();
        m_ovf = 0; m_unf = 0; m_inx = 0; m_drop = 0;
    endtask

    task automatic check_all();
        logic [36:0] h;
        h = (model_q.size() > 0) ? model_q[0] : 37'd0;
        chk("level",  64'(level_out),     64'(model_q.size()));
        chk("valid",  64'(rd_valid_out),  64'(model_q.size() > 0));
        chk("empty",  64'(empty_out),     64'(model_q.size() == 0));
        chk("full",   64'(full_out),      64'(model_q.size() == DEPTH));
        chk("data",   64'(rd_data_out),   64'(h[31:0]));
        chk("status", 64'(rd_status_out), 64'(h[35:32]));
        chk("flags",  64'(rd_flags_out),  64'(h[36]));
        chk("ovf",    64'(ovf_cnt_out),   64'(m_ovf));
        chk("unf",    64'(unf_cnt_out),   64'(m_unf));
        chk("inx",    64'(inx_cnt_out),   64'(m_inx));
        chk("drop",   64'(drop_cnt_out),  64'(m_drop));
    endtask

    // One clock cycle: drive inputs, advance the model, check after the edge.
    task automatic step(input logic v, input logic [31:0] d, input logic [3:0] s,
                        input logic f, input logic r, input logic clr);
        bit was_full, do_pop, do_push;
        res_valid_in = v; data_in = d; status_in = s; flags_in = f;
        rd_ready_in = r; clear_cnt_in = clr;
        was_full = (model_q.size() == DEPTH);
        do_pop   = (model_q.size() > 0) && r;
        do_push  = v && (!was_full || do_pop);
        if (do_pop) void'(model_q.pop_front());
        if (do_push) model_q.push_back({f, s, d});
        if (clr) begin
            m_ovf = 0; m_unf = 0; m_inx = 0; m_drop = 0;
        end else begin
            m_ovf  = sat(m_ovf,  do_push && s[1]);
            m_unf  = sat(m_unf,  do_push && s[2]);
            m_inx  = sat(m_inx,  do_push && s[3]);
            m_drop = sat(m_drop, v && was_full && !do_pop);
        end
        @(posedge clk);
        #1;
        check_all();
    endtask

    task automatic idle();
        step(1'b0, 32'd0, 4'd0, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        logic [3:0] st;
        rst_n = 1'b0;
        res_valid_in = 1'b0; data_in = '0; status_in = '0; flags_in = 1'b0;
        rd_ready_in = 1'b0; clear_cnt_in = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_all();
        @(negedge clk);
        rst_n = 1'b1;

        // Push into empty: visible on the next cycle, held while not ready.
        step(1'b1, 32'h3F80_0000, 4'b0001, 1'b0, 1'b0, 1'b0);
        chk("first_data", 64'(rd_data_out), 64'h3F80_0000);
        idle();
        step(1'b0, 32'd0, 4'd0, 1'b0, 1'b1, 1'b0);

        // Fill with 1..8, then an overflow result that must be dropped and not counted.
        for (int i = 1; i <= DEPTH; i++) step(1'b1, 32'(i), 4'b0001, i[0], 1'b0, 1'b0);
        step(1'b1, 32'd9, 4'b0010, 1'b0, 1'b0, 1'b0);
        chk("drop_one", 64'(drop_cnt_out), 64'd1);
        chk("ovf_zero", 64'(ovf_cnt_out), 64'd0);

        // Push+pop at full: level stays, head advances, no drop.
        step(1'b1, 32'hAB, 4'b0100, 1'b1, 1'b1, 1'b0);
        chk("full_pp_head", 64'(rd_data_out), 64'd2);
        for (int i = 0; i < DEPTH + 2; i++) step(1'b0, 32'd0, 4'd0, 1'b0, 1'b1, 1'b0);

        // Pop while empty is ignored.
        step(1'b0, 32'd0, 4'd0, 1'b0, 1'b1, 1'b0);

        // Inexact counter saturation while draining.
        for (int i = 0; i < 300; i++) step(1'b1, $urandom, 4'b1000, 1'b0, 1'b1, 1'b0);
        chk("inx_sat", 64'(inx_cnt_out), 64'(CMAX));
        step(1'b0, 32'd0, 4'd0, 1'b0, 1'b1, 1'b0);

        // Clear wins over a coincident underflow push; entry still stored.
        step(1'b1, 32'h5555, 4'b0100, 1'b0, 1'b0, 1'b1);
        chk("clr_unf", 64'(unf_cnt_out), 64'd0);
        chk("clr_stored", 64'(rd_data_out), 64'h5555);

        // Async reset mid-stream with 3 entries stored.
        step(1'b1, 32'h11, 4'b0010, 1'b0, 1'b0, 1'b0);
        step(1'b1, 32'h22, 4'b0100, 1'b0, 1'b0, 1'b0);
        chk("pre_rst_lvl", 64'(level_out), 64'd3);
        res_valid_in = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        check_all();
        @(negedge clk);
        rst_n = 1'b1;

        // Random phases with varying arrival and drain rates.
        for (int ph = 0; ph < 4; ph++) begin
            int pv, pr;
            pv = (ph == 0) ? 90 : (ph == 1) ? 30 : (ph == 2) ? 70 : 50;
            pr = (ph == 0) ? 20 : (ph == 1) ? 90 : (ph == 2) ? 70 : 50;
            for (int c = 0; c < 500; c++) begin
                st = ($urandom_range(0, 9) == 0) ? 4'($urandom) : 4'(1 << $urandom_range(0, 3));
                step($urandom_range(0, 99) < pv, $urandom, st, 1'($urandom),
                     $urandom_range(0, 99) < pr, $urandom_range(0, 99) < 2);
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
